serial_tx_uart: RTL and testbench
=================================

Name: serial_tx_uart

Overview:
- Downstream consumer of the processor's serial write port.
- Accepts bytes presented on `serial_out`/`serial_wren_out` and buffers them in a small FIFO.
- Serializes them onto a single UART line, 8N1, LSB first.
- Returns FIFO space status, which the top level wires to the processor's `serial_ready_in`.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, byte entries in the transmit FIFO; must be a power of two, at least 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to transmit; connects to processor `serial_out`.
- wren_in  in  1  write strobe, one byte per cycle when high; connects to `serial_wren_out`.
- ready_out  out  1  high when the FIFO is not full; connects to processor `serial_ready_in`.
- tx_out  out  1  UART line; idle level is 1.
- busy_out  out  1  high while a frame is on the line or the FIFO is non-empty.
- count_out  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow_out  out  1  sticky flag, set when a write arrives while full.

Behaviour:
- Reset (async, active-high):
  - Takes effect immediately, including mid-frame.
  - Outputs: tx_out=1, ready_out=1, busy_out=0, count_out=0, overflow_out=0.
  - FIFO pointers cleared, FSM forced to IDLE, baud counter and bit index cleared.
  - Bytes held at reset are discarded.
- FIFO:
  - Circular buffer with ADDR_W-bit read/write pointers that wrap modulo FIFO_DEPTH.
  - Occupancy counter is ADDR_W+1 bits wide.
  - ready_out = (count != FIFO_DEPTH), driven from registered state.
- Write:
  - If wren_in=1 and ready_out=1 at an edge, data_in is stored at the write pointer.
  - Count reflects the write after that same edge.
  - If wren_in=1 while full, the byte is dropped and overflow_out is set; it stays set until reset.
  - A write while full is rejected even if a pop occurs on the same edge.
- Simultaneous write and pop on the same edge (not full): count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_out=1.
  - At an edge with count>0: pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - A byte written at edge E0 into an empty FIFO is popped at E0+1, so tx_out falls after E0+1.
- START:
  - tx_out=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - tx_out = shift[0] for CLKS_PER_BIT cycles per bit; the shift register shifts right after each bit.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - In the final cycle, if count>0: pop and go directly to START (back-to-back frames, no extra idle cycle).
  - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the falling edge of tx_out to the end of the stop bit.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at bit boundaries; its width is 16 bits.
- tx_out is driven from a flop; no combinational glitches.
- busy_out = (state != IDLE) || (count != 0).
- wren_in has no effect on a frame already in progress.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset, single write, idle return:
   - Stimulus: reset, then write 0xA5 at cycle 10.
   - Required: tx_out falls after cycle 11, giving start bit then 1,0,1,0,0,1,0,1 then stop, each held 4 cycles.
   - Required: busy_out drops 40 cycles after the fall.
2. Back-to-back frames:
   - Stimulus: write 0x00 then 0xFF on consecutive cycles.
   - Required: the second start bit begins exactly 40 cycles after the first, and count_out is 1 during the first frame.
3. Full and overflow:
   - Stimulus: write 6 bytes on consecutive cycles starting from empty, with the FSM idle.
   - Required: the first byte is popped at the next edge, so 5 fit (4 stored plus 1 in flight).
   - Required: ready_out=0 after the 5th write, the 6th is dropped, and overflow_out=1 until reset.
4. Pointer wrap:
   - Stimulus: stream 10 bytes 0x01..0x0A, writing only while ready_out=1.
   - Required: the decoded line output equals 0x01..0x0A in order, with overflow_out=0.
5. Write when full plus pop on the same edge:
   - Stimulus: with count=4, assert wren_in on the STOP final-cycle edge.
   - Required: the byte is dropped, overflow_out=1, and count_out becomes 3.
6. Reset mid-frame:
   - Stimulus: assert reset during DATA bit 3 of 0x3C.
   - Required: tx_out=1 immediately (same cycle, async), count_out=0, and no further frame after reset is released.

Source files
------------

// File: rtl/serial_tx_uart.sv
// serial_tx_uart: byte FIFO feeding an 8N1 LSB-first UART transmitter.
// ready_out reports FIFO space back to the processor serial write port.
module serial_tx_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              wren_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy_out,
  output logic [ADDR_W:0]   count_out,
  output logic              overflow_out
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic full, empty, baud_end, push, pop;

  assign full     = (count_q == FULL);
  assign empty    = (count_q == '0);
  assign baud_end = (baud_q == BAUD_LAST);
  assign push     = wren_in && !full;

  // State register and all datapath flops; reset aborts any frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= data_in;
  end

  // Next-state logic: bit timing, shifting and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the next cycle, registered so tx_out never glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointer, occupancy and sticky overflow update.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wren_in & full);
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  assign ready_out    = !full;
  assign tx_out       = tx_q;
  assign busy_out     = (state_q != IDLE) || !empty;
  assign count_out    = count_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_serial_tx_uart.sv
// tb_serial_tx_uart: directed checks of serial_tx_uart
// with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_serial_tx_uart;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       wren_in;
  logic       ready_out;
  logic       tx_out;
  logic       busy_out;
  logic [2:0] count_out;
  logic       overflow_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_q[$];

  serial_tx_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4),
    .ADDR_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .wren_in(wren_in),
    .ready_out(ready_out),
    .tx_out(tx_out),
    .busy_out(busy_out),
    .count_out(count_out),
    .overflow_out(overflow_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b);
    for (int i = 0; i < 10 * CPB; i++) begin
      check(tag, tx_out, frame_bit(b, i / CPB));
      if (i == 10 * CPB - 1) check({tag, "_busy"}, busy_out, 1);
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_out && n < 2000) begin
      step();
      n++;
    end
    check(tag, int'(n < 2000), 1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in = b;
    wren_in = 1'b1;
    step();
    wren_in = 1'b0;
  endtask

  // Line decoder: samples mid-bit on falling clock edges.
  initial begin
    logic [7:0] b;
    logic st, sp;
    forever begin
      @(negedge tx_out);
      repeat (2) @(negedge clock);
      st = tx_out;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clock);
        b[k] = tx_out;
      end
      repeat (CPB) @(negedge clock);
      sp = tx_out;
      if (!st && sp) rx_q.push_back(b);
    end
  end

  initial begin
    int n;
    int lows;
    reset   = 1'b1;
    wren_in = 1'b0;
    data_in = 8'h00;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_tx", tx_out, 1);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_count", count_out, 0);
    check("rst_ovf", overflow_out, 0);

    // single frame
    repeat (7) step();
    write_byte(8'hA5);
    check("t1_cnt1", count_out, 1);
    check("t1_tx_hi", tx_out, 1);
    check("t1_busy", busy_out, 1);
    step();
    check("t1_cnt0", count_out, 0);
    check_frame("t1_a5", 8'hA5);
    check("t1_idle", busy_out, 0);
    check("t1_txidle", tx_out, 1);

    // back-to-back frames
    repeat (3) step();
    data_in = 8'h00;
    wren_in = 1'b1;
    step();
    data_in = 8'hFF;
    step();
    wren_in = 1'b0;
    check("t2_cnt", count_out, 1);
    check_frame("t2_f0", 8'h00);
    check("t2_cnt0", count_out, 0);
    check_frame("t2_f1", 8'hFF);
    check("t2_idle", busy_out, 0);

    // full and overflow
    repeat (3) step();
    rx_q.delete();
    for (int j = 0; j < 6; j++) begin
      if (j == 4) check("t3_rdy4", ready_out, 1);
      if (j == 5) check("t3_rdy5", ready_out, 0);
      write_byte(8'h10 + 8'(j));
    end
    check("t3_ovf", overflow_out, 1);
    check("t3_cnt", count_out, 4);
    wait_idle("t3_drain");
    check("t3_ovf_held", overflow_out, 1);
    check("t3_nrx", rx_q.size(), 5);
    n = (rx_q.size() < 5) ? rx_q.size() : 5;
    for (int j = 0; j < n; j++) check("t3_rx", rx_q[j], 8'h10 + j);
    do_reset();
    check("t3_ovf_clr", overflow_out, 0);

    // pointer wrap while streaming
    rx_q.delete();
    for (int j = 1; j <= 10; j++) begin
      n = 0;
      while (!ready_out && n < 1000) begin
        step();
        n++;
      end
      check("t4_rdy_to", int'(n < 1000), 1);
      write_byte(8'(j));
    end
    wait_idle("t4_drain");
    check("t4_nrx", rx_q.size(), 10);
    n = (rx_q.size() < 10) ? rx_q.size() : 10;
    for (int j = 0; j < n; j++) check("t4_rx", rx_q[j], j + 1);
    check("t4_ovf", overflow_out, 0);

    // write while full on the pop edge
    do_reset();
    for (int j = 0; j < 5; j++) write_byte(8'h20 + 8'(j));
    repeat (36) step();
    check("t5_cnt4", count_out, 4);
    check("t5_stop", tx_out, 1);
    check("t5_ovf0", overflow_out, 0);
    write_byte(8'h77);
    check("t5_cnt3", count_out, 3);
    check("t5_ovf1", overflow_out, 1);
    check("t5_start", tx_out, 0);

    // reset mid-frame
    do_reset();
    data_in = 8'h3C;
    wren_in = 1'b1;
    step();
    data_in = 8'h55;
    step();
    wren_in = 1'b0;
    check("t6_fall", tx_out, 0);
    repeat (13) step();
    check("t6_bit2", tx_out, 1);
    repeat (4) step();
    check("t6_bit3", tx_out, 1);
    check("t6_cnt1", count_out, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_tx", tx_out, 1);
    check("t6_cnt", count_out, 0);
    check("t6_busy", busy_out, 0);
    check("t6_ready", ready_out, 1);
    step();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!tx_out || busy_out) lows++;
    end
    check("t6_quiet", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
